// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t         : FSM state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH   : default operand/result width
//   product_negative: sign helper, present only when MULT_SIGNED_EN is defined
// Build option: define MULT_SIGNED_EN for two's-complement operands.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 21;

`ifdef MULT_SIGNED_EN
  // The core multiplies magnitudes; the product is negative exactly when
  // the operand signs differ.
  function automatic logic product_negative(input logic sign_a, input logic sign_b);
    return sign_a ^ sign_b;
  endfunction
`endif

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Shift-add datapath: latched operands, 2*WIDTH accumulator, iteration counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : latch operands (magnitudes in signed builds), clear acc/counter
//   step       : process multiplier bit[counter], advance counter
//   a, b       : multiplicand / multiplier inputs
//   result     : accumulated product (sign-corrected when MULT_SIGNED_EN)
//   last       : current step is the final iteration (counter == WIDTH-1)
// Build option: MULT_SIGNED_EN.
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef MULT_SIGNED_EN
  logic neg;

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= product_negative(a[WIDTH-1], b[WIDTH-1]);
    end
  end

  always_comb begin
    result = neg ? (~acc + (2*WIDTH)'(1)) : acc;
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    result = acc;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a_mag;
      mplier <= b_mag;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[cnt]) begin
        acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with start/done handshake.
//   Clock, Reset     : rising-edge clock, synchronous active-high reset
//   Start            : request, accepted only in IDLE
//   Number0, Number1 : multiplicand / multiplier, latched on acceptance
//   Busy             : operation in flight (RUN, DONE and the Done cycle)
//   Done             : one-cycle pulse, result valid
//   outputNumber     : low WIDTH bits of the product, held until next Done
//   Overflow         : product not representable in WIDTH bits, held
// Build option: MULT_SIGNED_EN selects two's-complement operands.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Number0,
  input  logic [WIDTH-1:0] Number1,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] outputNumber,
  output logic             Overflow
);

  state_t             state;
  state_t             next_state;
  logic               load;
  logic               step;
  logic               last;
  logic               done_q;
  logic               ovf_next;
  logic [2*WIDTH-1:0] prod;

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (Clock),
    .reset  (Reset),
    .load   (load),
    .step   (step),
    .a      (Number0),
    .b      (Number1),
    .result (prod),
    .last   (last)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (Start) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Done is registered on the DONE->IDLE edge, so Busy also covers the
  // Done cycle to keep it high for the whole operation.
  always_comb begin
    load = (state == IDLE) && Start;
    step = (state == RUN);
    Busy = (state != IDLE) || done_q;
  end

`ifdef MULT_SIGNED_EN
  // Representable iff the top WIDTH+1 bits are a pure sign extension.
  always_comb begin
    ovf_next = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
  end
`else
  always_comb begin
    ovf_next = |prod[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      done_q       <= 1'b0;
      outputNumber <= '0;
      Overflow     <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (state == DONE) begin
        outputNumber <= prod[WIDTH-1:0];
        Overflow     <= ovf_next;
      end
    end
  end

  assign Done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=21); honours MULT_SIGNED_EN.
module tb_seq_multiplier;

  localparam int W = 21;
  localparam int NLIT = 12;

  logic         clk = 1'b0;
  logic         Reset, Start;
  logic [W-1:0] Number0, Number1;
  logic         Busy, Done, Overflow;
  logic [W-1:0] outputNumber;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clock        (clk),
    .Reset        (Reset),
    .Start        (Start),
    .Number0      (Number0),
    .Number1      (Number1),
    .Busy         (Busy),
    .Done         (Done),
    .outputNumber (outputNumber),
    .Overflow     (Overflow)
  );

  always #5 clk = ~clk;

  // Hand-computed results, in the order the stimulus produces them.
  logic [W-1:0] lit_out [NLIT];
  logic         lit_ovf [NLIT];

  // ---------------- behavioural model ----------------
  int           edges = 0;
  int           m_t0 = 0;
  bit           pend = 0, m_done = 0, m_rst = 0;
  logic [W-1:0] m_out = '0, r_out = '0;
  logic         m_ovf = 1'b0, r_ovf = 1'b0;

  function automatic void mul_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] o, output logic ov);
`ifdef MULT_SIGNED_EN
    longint p;
    p  = longint'($signed(a)) * longint'($signed(b));
    o  = p[W-1:0];
    ov = (p > longint'((1 << (W-1)) - 1)) || (p < -longint'(1 << (W-1)));
`else
    logic [63:0] p;
    p  = 64'(a) * 64'(b);
    o  = p[W-1:0];
    ov = (p >> W) != 64'd0;
`endif
  endfunction

  // Cycle-count model: accept when idle, result appears W+1 edges later.
  always @(posedge clk) begin
    edges = edges + 1;
    m_rst = Reset;
    if (Reset) begin
      pend = 0; m_done = 0; m_out = '0; m_ovf = 1'b0;
    end else begin
      m_done = 0;
      if (pend) begin
        if (edges - m_t0 == W + 1) begin
          m_done = 1; m_out = r_out; m_ovf = r_ovf; pend = 0;
        end
      end else if (Start) begin
        pend = 1; m_t0 = edges;
        mul_model(Number0, Number1, r_out, r_ovf);
      end
    end
  end

  // ---------------- compare process ----------------
  int  tests = 0, fails = 0;
  int  done_idx = 0, stall = 0;
  bit  cmp_en = 0, end_req = 0, end_ack = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(Busy), 64'(pend || m_done));
      chk("done", 64'(Done), 64'(m_done));
      chk("out", 64'(outputNumber), 64'(m_out));
      chk("ovf", 64'(Overflow), 64'(m_ovf));
      if (m_rst) begin
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_out", 64'(outputNumber), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
      end
      if (Done === 1'b1) begin
        if (done_idx < NLIT) begin
          chk("latency", 64'(edges - m_t0), 64'(W + 1));
          chk("lit_out", 64'(outputNumber), 64'(lit_out[done_idx]));
          chk("lit_ovf", 64'(Overflow), 64'(lit_ovf[done_idx]));
          chk("model_out", 64'(m_out), 64'(lit_out[done_idx]));
          chk("model_ovf", 64'(m_ovf), 64'(lit_ovf[done_idx]));
        end else begin
          chk("extra_done", 64'(done_idx), 64'(NLIT - 1));
        end
        done_idx++;
        stall = 0;
      end else if (Busy !== 1'b0) begin
        stall++;
        if (stall == 3 * W) chk("stall", 64'(stall), 64'(W + 1));
      end else begin
        stall = 0;
      end
      if (end_req && !end_ack) begin
        chk("done_count", 64'(done_idx), 64'(NLIT));
        end_ack = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); Number0 = a; Number1 = b; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    Number0 = W'($urandom); Number1 = W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Busy === 1'b0 && Done === 1'b0) break;
    end
  endtask

  initial begin
    bit sg;
`ifdef MULT_SIGNED_EN
    sg = 1;
`else
    sg = 0;
`endif
    lit_out[0]  = 21'd15;       lit_ovf[0]  = 1'b0;
    lit_out[1]  = 21'h1FFFFF;   lit_ovf[1]  = 1'b0;
    lit_out[2]  = 21'd0;        lit_ovf[2]  = 1'b1;
    lit_out[3]  = 21'd0;        lit_ovf[3]  = 1'b0;
    lit_out[4]  = 21'd799668;   lit_ovf[4]  = 1'b0;
    lit_out[5]  = 21'd42;       lit_ovf[5]  = 1'b0;
    lit_out[6]  = 21'd4;        lit_ovf[6]  = 1'b0;
    lit_out[7]  = 21'd4;        lit_ovf[7]  = 1'b0;
    lit_out[8]  = 21'd4;        lit_ovf[8]  = 1'b0;
    lit_out[9]  = 21'h1FFFF1;   lit_ovf[9]  = !sg;
    lit_out[10] = 21'h100000;   lit_ovf[10] = 1'b1;
    lit_out[11] = 21'd1;        lit_ovf[11] = !sg;

    Reset = 1'b1; Start = 1'b0; Number0 = '0; Number1 = '0;
    @(negedge clk); @(negedge clk);
    #1 cmp_en = 1;
    @(negedge clk); Reset = 1'b0;

    start_op(21'd3, 21'd5);              wait_idle();
    start_op(21'h1FFFFF, 21'd1);         wait_idle();
    start_op(21'h1000, 21'h1000);        wait_idle();
    start_op(21'd0, 21'h12345);          wait_idle();

    // Second Start mid-operation must be ignored.
    start_op(21'hABC, 21'h123);
    repeat (3) @(negedge clk);
    @(negedge clk); Number0 = 21'd9; Number1 = 21'd9; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    wait_idle();

    // Reset in the middle of RUN aborts without a Done.
    start_op(21'd11, 21'd13);
    repeat (8) @(negedge clk);
    @(negedge clk); Reset = 1'b1;
    @(negedge clk); Reset = 1'b0;
    repeat (30) @(negedge clk);
    start_op(21'd7, 21'd6);              wait_idle();

    // Start held high: three back-to-back operations.
    @(negedge clk); Number0 = 21'd2; Number1 = 21'd2; Start = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 100 && n < 3; i++) begin
        @(negedge clk);
        if (Done === 1'b1) n++;
      end
    end
    Start = 1'b0;
    wait_idle();

    start_op(21'h1FFFFD, 21'd5);         wait_idle();
    start_op(21'h100000, 21'h1FFFFF);    wait_idle();
    start_op(21'h1FFFFF, 21'h1FFFFF);    wait_idle();

    end_req = 1;
    @(negedge clk); @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
